// File: rtl/alu_ctrl_unit.sv
// Registered ALU control decoder: RV32I R/I ALU ops plus optional M ops.
// Valid/ready on both sides; M ops are sequenced for MDU_LAT cycles.
module alu_ctrl_unit #(
  parameter int CTRL_W    = 4,
  parameter int MDU_LAT   = 4,
  parameter int SUPPORT_M = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [1:0]        alu_op_i,
  input  logic [6:0]        funct7_i,
  input  logic [2:0]        funct3_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] alu_ctrl_o,
  output logic              mdu_op_o,
  output logic              illegal_o,
  output logic              busy_o
);

  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_XOR = 4'b0011;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_SLT = 4'b0111;
  localparam logic [3:0] C_SLL = 4'b1000;
  localparam logic [3:0] C_SRL = 4'b1001;
  localparam logic [3:0] C_SRA = 4'b1010;
  localparam logic [3:0] C_MUL = 4'b1100;
  localparam logic [3:0] C_DIV = 4'b1101;
  localparam logic [3:0] C_REM = 4'b1110;

  localparam int CW = $clog2(MDU_LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    MDU
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    pend;
  logic [3:0]    dec_code;
  logic          dec_mdu;
  logic          dec_ill;
  logic          accept;
  logic          m_ok;

  assign m_ok = (funct7_i == 7'b0000001) && (SUPPORT_M != 0);

  always_comb begin
    dec_code = C_ADD;
    dec_mdu  = 1'b0;
    dec_ill  = 1'b0;
    case (alu_op_i)
      2'b00: dec_code = C_ADD;
      2'b01: dec_code = C_SUB;
      2'b11: begin
        case (funct3_i)
          3'b000: dec_code = C_ADD;
          3'b001: dec_code = C_SLL;
          3'b010: dec_code = C_SLT;
          3'b100: dec_code = C_XOR;
          3'b101: dec_code = funct7_i[5] ? C_SRA : C_SRL;
          3'b110: dec_code = C_OR;
          3'b111: dec_code = C_AND;
          default: dec_ill = 1'b1;
        endcase
      end
      default: begin
        unique case (1'b1)
          funct7_i == 7'b0000000: begin
            case (funct3_i)
              3'b000: dec_code = C_ADD;
              3'b001: dec_code = C_SLL;
              3'b010: dec_code = C_SLT;
              3'b100: dec_code = C_XOR;
              3'b101: dec_code = C_SRL;
              3'b110: dec_code = C_OR;
              3'b111: dec_code = C_AND;
              default: dec_ill = 1'b1;
            endcase
          end
          funct7_i == 7'b0100000: begin
            case (funct3_i)
              3'b000: dec_code = C_SUB;
              3'b101: dec_code = C_SRA;
              default: dec_ill = 1'b1;
            endcase
          end
          m_ok: begin
            case (funct3_i)
              3'b000: begin
                dec_code = C_MUL;
                dec_mdu  = 1'b1;
              end
              3'b100: begin
                dec_code = C_DIV;
                dec_mdu  = 1'b1;
              end
              3'b110: begin
                dec_code = C_REM;
                dec_mdu  = 1'b1;
              end
              default: dec_ill = 1'b1;
            endcase
          end
          default: dec_ill = 1'b1;
        endcase
      end
    endcase
  end

  assign in_ready_o = rst_i &
    ((state == IDLE) |
     ((state == HOLD) & out_ready_i));

  assign accept = in_valid_i & in_ready_o;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      pend        <= '0;
      out_valid_o <= 1'b0;
      alu_ctrl_o  <= '0;
      mdu_op_o    <= 1'b0;
      illegal_o   <= 1'b0;
      busy_o      <= 1'b0;
    end else if (accept) begin
      if (dec_mdu) begin
        state       <= MDU;
        cnt         <= CW'(MDU_LAT - 1);
        pend        <= dec_code;
        busy_o      <= 1'b1;
        out_valid_o <= 1'b0;
      end else begin
        state       <= HOLD;
        out_valid_o <= 1'b1;
        alu_ctrl_o  <= CTRL_W'(dec_code);
        mdu_op_o    <= 1'b0;
        illegal_o   <= dec_ill;
      end
    end else if (state == HOLD) begin
      if (out_ready_i) begin
        state       <= IDLE;
        out_valid_o <= 1'b0;
      end
    end else if (state == MDU) begin
      // Result appears on the same edge busy drops.
      if (cnt == CW'(1)) begin
        state       <= HOLD;
        cnt         <= '0;
        busy_o      <= 1'b0;
        out_valid_o <= 1'b1;
        alu_ctrl_o  <= CTRL_W'(pend);
        mdu_op_o    <= 1'b1;
        illegal_o   <= 1'b0;
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_unit.sv
// Scoreboard bench for alu_ctrl_unit: directed cases plus random traffic
// against a table-driven reference model, SUPPORT_M=1 and SUPPORT_M=0.
module tb_alu_ctrl_unit;

  localparam int LAT = 4;
  localparam int C_AND = 0, C_OR = 1, C_ADD = 2, C_XOR = 3;
  localparam int C_SUB = 6, C_SLT = 7, C_SLL = 8, C_SRL = 9;
  localparam int C_SRA = 10, C_MUL = 12, C_DIV = 13, C_REM = 14;

  typedef struct {
    int code;
    bit mdu;
    bit ill;
    int cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] alu_op;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic       out_ready;
  logic       in_ready, out_valid, mdu_op, illegal, busy;
  logic [3:0] alu_ctrl;
  logic       n_in_ready, n_out_valid, n_mdu, n_ill, n_busy;
  logic [3:0] n_ctrl;
  logic       n_out_ready;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pops = 0;
  exp_t q[$];
  exp_t nq[$];
  bit stall = 0;
  logic [3:0] h_ctrl;
  logic h_mdu, h_ill;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign n_out_ready = 1'b1;

  alu_ctrl_unit #(.CTRL_W(4), .MDU_LAT(LAT), .SUPPORT_M(1)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .alu_op_i(alu_op), .funct7_i(funct7), .funct3_i(funct3),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .alu_ctrl_o(alu_ctrl), .mdu_op_o(mdu_op),
    .illegal_o(illegal), .busy_o(busy)
  );

  alu_ctrl_unit #(.CTRL_W(4), .MDU_LAT(LAT), .SUPPORT_M(0)) nom (
    .clk_i(clk), .rst_i(rst_n),
    .in_valid_i(in_valid), .in_ready_o(n_in_ready),
    .alu_op_i(alu_op), .funct7_i(funct7), .funct3_i(funct3),
    .out_valid_o(n_out_valid), .out_ready_i(n_out_ready),
    .alu_ctrl_o(n_ctrl), .mdu_op_o(n_mdu),
    .illegal_o(n_ill), .busy_o(n_busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op,
                                 input logic [6:0] f7,
                                 input logic [2:0] f3,
                                 input bit m);
    exp_t e;
    int t[8];
    e = '{code: C_ADD, mdu: 1'b0, ill: 1'b0, cyc: 0};
    t = '{C_ADD, C_SLL, C_SLT, -1, C_XOR, C_SRL, C_OR, C_AND};
    if (op == 2'd0) e.code = C_ADD;
    else if (op == 2'd1) e.code = C_SUB;
    else if (op == 2'd3) begin
      if (f7[5]) t[5] = C_SRA;
      e.code = t[f3];
    end else if (f7 == 7'h00) e.code = t[f3];
    else if (f7 == 7'h20)
      e.code = (f3 == 0) ? C_SUB : (f3 == 5) ? C_SRA : -1;
    else if (f7 == 7'h01 && m) begin
      e.code = (f3 == 0) ? C_MUL : (f3 == 4) ? C_DIV :
               (f3 == 6) ? C_REM : -1;
      e.mdu = (e.code != -1);
    end else e.code = -1;
    if (e.code < 0) begin
      e.code = C_ADD;
      e.ill = 1'b1;
      e.mdu = 1'b0;
    end
    return e;
  endfunction

  // Monitor: pops expected results when the DUTs present them.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      nq.delete();
      stall = 0;
    end else begin
      if (out_valid) begin
        if (stall) begin
          chk("stall_ctrl", alu_ctrl, h_ctrl);
          chk("stall_mdu", mdu_op, h_mdu);
          chk("stall_ill", illegal, h_ill);
        end else if (q.size() > 0) begin
          chk("dut_latency", cyc - q[0].cyc, q[0].mdu ? LAT : 1);
        end
        if (out_ready) begin
          if (q.size() == 0) chk("dut_spurious", 0, 1);
          else begin
            e = q.pop_front();
            chk("dut_ctrl", alu_ctrl, e.code);
            chk("dut_mdu", mdu_op, e.mdu);
            chk("dut_ill", illegal, e.ill);
          end
          pops++;
          stall = 0;
        end else begin
          stall = 1;
          h_ctrl = alu_ctrl;
          h_mdu = mdu_op;
          h_ill = illegal;
        end
      end else stall = 0;
      if (busy) begin
        chk("busy_ready", in_ready, 0);
        chk("busy_valid", out_valid, 0);
      end
      if (in_valid && in_ready) begin
        e = model(alu_op, funct7, funct3, 1'b1);
        e.cyc = cyc;
        q.push_back(e);
      end
      if (n_out_valid) begin
        if (nq.size() == 0) chk("nom_spurious", 0, 1);
        else begin
          e = nq.pop_front();
          chk("nom_latency", cyc - e.cyc, 1);
          chk("nom_ctrl", n_ctrl, e.code);
          chk("nom_mdu", n_mdu, e.mdu);
          chk("nom_ill", n_ill, e.ill);
        end
      end
      if (in_valid && n_in_ready) begin
        e = model(alu_op, funct7, funct3, 1'b0);
        e.cyc = cyc;
        nq.push_back(e);
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [6:0] f7,
                      input logic [2:0] f3, output int waits);
    in_valid = 1'b1;
    alu_op = op;
    funct7 = f7;
    funct3 = f3;
    waits = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits > 50) begin
        chk("send_timeout", waits, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  initial begin
    int w;
    int p0;
    int r;
    rst_n = 1'b0;
    in_valid = 1'b0;
    alu_op = '0;
    funct7 = '0;
    funct3 = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ctrl", alu_ctrl, 0);
    chk("rst_ill", illegal, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1);
    @(posedge clk);
    #1;

    send(2'd2, 7'h20, 3'd0, w);
    idle();
    @(negedge clk);
    chk("sub_valid", out_valid, 1);
    chk("sub_ctrl", alu_ctrl, C_SUB);
    chk("sub_ill", illegal, 0);
    @(posedge clk);
    #1;

    p0 = pops;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) send(2'd3, 7'($urandom), 3'($urandom), w);
      else send(2'd2, 7'h00, 3'($urandom), w);
      chk("stream_ready", w, 0);
    end
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("stream_count", pops - p0, 8);

    send(2'd2, 7'h01, 3'd4, w);
    idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("div_busy", busy, 1);
      chk("div_ready", in_ready, 0);
      chk("div_novalid", out_valid, 0);
    end
    @(negedge clk);
    chk("div_valid", out_valid, 1);
    chk("div_busy_drop", busy, 0);
    chk("div_ctrl", alu_ctrl, C_DIV);
    chk("div_mdu", mdu_op, 1);
    @(posedge clk);
    #1;

    out_ready = 1'b0;
    send(2'd3, 7'h00, 3'd0, w);
    idle();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", in_ready, 0);
      chk("hold_ctrl", alu_ctrl, C_ADD);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("hold_release", out_valid, 1);
    @(posedge clk);
    @(negedge clk);
    chk("hold_idle_valid", out_valid, 0);
    chk("hold_idle_ready", in_ready, 1);
    @(posedge clk);
    #1;

    send(2'd2, 7'h7f, 3'($urandom), w);
    idle();
    @(negedge clk);
    chk("ill_f7", illegal, 1);
    chk("ill_f7_ctrl", alu_ctrl, C_ADD);
    @(posedge clk);
    #1;
    send(2'd3, 7'($urandom), 3'd3, w);
    idle();
    @(negedge clk);
    chk("ill_i011", illegal, 1);
    chk("ill_i011_ctrl", alu_ctrl, C_ADD);
    @(posedge clk);
    #1;

    send(2'd2, 7'h01, 3'd0, w);
    idle();
    @(negedge clk);
    chk("nom_mul_valid", n_out_valid, 1);
    chk("nom_mul_ill", n_ill, 1);
    chk("nom_mul_ctrl", n_ctrl, C_ADD);
    repeat (6) @(posedge clk);
    #1;

    send(2'd2, 7'h01, 3'd0, w);
    idle();
    @(negedge clk);
    chk("mid_busy", busy, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_ctrl", alu_ctrl, 0);
    chk("mid_rst_mdu", mdu_op, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1);
    for (int k = 0; k < 6; k++) begin
      chk("post_rst_stale", out_valid, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;

    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom % 10) < 6;
      alu_op = 2'($urandom);
      r = $urandom % 4;
      funct7 = (r == 0) ? 7'h00 : (r == 1) ? 7'h20 :
               (r == 2) ? 7'h01 : 7'($urandom);
      funct3 = 3'($urandom);
      out_ready = ($urandom % 10) < 7;
      @(posedge clk);
      #1;
    end

    idle();
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (q.size() == 0 && !out_valid && !busy) break;
      @(posedge clk);
      #1;
    end
    chk("drain_dut", q.size(), 0);
    chk("drain_nom", nq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
